note2dds_2nd_gen: RTL and testbench

NOTE2DDS_2ND_GEN -- requirements
Module: note2dds_2nd_gen

---
 rtl/note2dds_2nd_gen.sv | 196 +++++++++++++++++++
 tb/tb_note2dds_2nd_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/note2dds_2nd_gen.sv
// MIDI note + pitch bend to per-voice DDS phase increment.
// Sequential octave divide, table interpolation, then a shifted write to one voice register.
module note2dds_2nd_gen #(
  parameter int unsigned AW     = 32,
  parameter int unsigned VOICES = 4,
  parameter int unsigned VW     = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   REQ_VALID,
  output logic                   REQ_READY,
  input  logic [6:0]             NOTE,
  input  logic [13:0]            BEND,
  input  logic [VW-1:0]          VOICE,
  output logic [VOICES*AW-1:0]   ADDER_BUS,
  output logic                   DONE,
  output logic [VW-1:0]          DONE_VOICE
);

  localparam int unsigned SW  = 7;   // semitone
  localparam int unsigned FW  = 6;   // 1/64 semitone fraction
  localparam int unsigned PW  = 13;  // clamped pitch
  localparam int unsigned BW  = 15;  // signed pitch arithmetic
  localparam int unsigned OW  = 4;   // octave count
  localparam int unsigned MW  = 20;  // table / mantissa
  localparam int unsigned IW  = 26;  // interpolation product
  localparam int unsigned VCW = VW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_INTERP,
    S_WRITE
  } state_t;

  state_t          state_q, state_d;
  logic            ready_q, ready_d;
  logic [SW-1:0]   r_q, r_d;
  logic [OW-1:0]   o_q, o_d;
  logic [FW-1:0]   f_q, f_d;
  logic [VW-1:0]   voice_q, voice_d;
  logic [MW-1:0]   m_q, m_d;
  logic            done_q, done_d;
  logic [VW-1:0]   done_voice_q, done_voice_d;
  logic [AW-1:0]   adder_q [VOICES];
  logic [AW-1:0]   adder_d [VOICES];

  logic signed [BW-1:0] bend_c;
  logic signed [BW-1:0] bend_off_c;
  logic signed [BW-1:0] pitch_raw_c;
  logic [PW-1:0]        pitch_c;
  logic [3:0]           idx_c;
  logic [MW-1:0]        t_lo_c;
  logic [MW-1:0]        t_hi_c;
  logic [IW-1:0]        diff_c;
  logic [IW-1:0]        prod_c;
  logic [MW-1:0]        interp_c;
  logic [AW-1:0]        a_val_c;
  logic                 voice_ok_c;

  // Equal-tempered semitone mantissas of the top octave, one extra entry for interpolation.
  function automatic logic [MW-1:0] tbl(input logic [3:0] idx);
    logic [MW-1:0] val;
    case (idx)
      4'd0:    val = 20'd359575;
      4'd1:    val = 20'd380957;
      4'd2:    val = 20'd403610;
      4'd3:    val = 20'd427610;
      4'd4:    val = 20'd453037;
      4'd5:    val = 20'd479976;
      4'd6:    val = 20'd508516;
      4'd7:    val = 20'd538754;
      4'd8:    val = 20'd570790;
      4'd9:    val = 20'd604731;
      4'd10:   val = 20'd640690;
      4'd11:   val = 20'd678787;
      4'd12:   val = 20'd719150;
      default: val = 20'd0;
    endcase
    return val;
  endfunction

  // Bent pitch in 1/64 semitone, floor-shifted offset, clamped to the MIDI range.
  always_comb begin
    bend_c      = $signed({1'b0, BEND}) - 15'sd8192;
    bend_off_c  = bend_c >>> 6;
    pitch_raw_c = $signed({2'b00, NOTE, 6'b000000}) + bend_off_c;
    pitch_c     = pitch_raw_c[PW-1:0];
    if (pitch_raw_c < 15'sd0) begin
      pitch_c = '0;
    end else if (pitch_raw_c > 15'sd8128) begin
      pitch_c = PW'(8128);
    end
  end

  // Linear interpolation between neighbouring table entries and final octave shift.
  always_comb begin
    idx_c      = r_q[3:0];
    t_lo_c     = tbl(idx_c);
    t_hi_c     = tbl(idx_c + 4'd1);
    diff_c     = IW'(t_hi_c) - IW'(t_lo_c);
    prod_c     = diff_c * IW'(f_q);
    interp_c   = MW'(IW'(t_lo_c) + (prod_c >> 6));
    a_val_c    = AW'(m_q >> (4'd10 - o_q));
    voice_ok_c = VCW'(voice_q) < VCW'(VOICES);
  end

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    o_d          = o_q;
    f_d          = f_q;
    voice_d      = voice_q;
    m_d          = m_q;
    done_d       = 1'b0;
    done_voice_d = done_voice_q;
    adder_d      = adder_q;

    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          r_d     = pitch_c[PW-1:FW];
          f_d     = pitch_c[FW-1:0];
          o_d     = '0;
          voice_d = VOICE;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (r_q >= 7'd12) begin
          r_d = r_q - 7'd12;
          o_d = o_q + 4'd1;
        end else begin
          state_d = S_INTERP;
        end
      end
      S_INTERP: begin
        m_d     = interp_c;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
        // Out-of-range voices complete silently.
        if (voice_ok_c) begin
          for (int unsigned v = 0; v < VOICES; v++) begin
            if (voice_q == VW'(v)) begin
              adder_d[v] = a_val_c;
            end
          end
          done_d       = 1'b1;
          done_voice_d = voice_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      r_q          <= '0;
      o_q          <= '0;
      f_q          <= '0;
      voice_q      <= '0;
      m_q          <= '0;
      done_q       <= 1'b0;
      done_voice_q <= '0;
      for (int unsigned v = 0; v < VOICES; v++) begin
        adder_q[v] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      r_q          <= r_d;
      o_q          <= o_d;
      f_q          <= f_d;
      voice_q      <= voice_d;
      m_q          <= m_d;
      done_q       <= done_d;
      done_voice_q <= done_voice_d;
      adder_q      <= adder_d;
    end
  end

  for (genvar gv = 0; gv < int'(VOICES); gv++) begin : g_bus
    assign ADDER_BUS[gv*AW +: AW] = adder_q[gv];
  end

  assign REQ_READY  = ready_q;
  assign DONE       = done_q;
  assign DONE_VOICE = done_voice_q;

endmodule

// File: tb/tb_note2dds_2nd_gen.sv
// Bench for note2dds_2nd_gen: directed cases plus random requests against an arithmetic model.
module tb_note2dds_2nd_gen;

  logic         CLK;
  logic         RST;
  logic         REQ_VALID;
  logic         REQ_READY;
  logic [6:0]   NOTE;
  logic [13:0]  BEND;
  logic [3:0]   VOICE;
  logic [127:0] ADDER_BUS;
  logic         DONE;
  logic [3:0]   DONE_VOICE;

  int n_checks = 0;
  int n_pass   = 0;
  bit clk_en   = 1'b0;
  int exp_adder [4];
  int tbl [13] = '{359575, 380957, 403610, 427610, 453037, 479976, 508516,
                   538754, 570790, 604731, 640690, 678787, 719150};

  note2dds_2nd_gen #(.AW(32), .VOICES(4), .VW(4)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .NOTE(NOTE), .BEND(BEND), .VOICE(VOICE), .ADDER_BUS(ADDER_BUS),
    .DONE(DONE), .DONE_VOICE(DONE_VOICE)
  );

  initial CLK = 1'b0;
  always begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  function automatic int model_pitch(int note, int bend);
    int d, off, p;
    d   = bend - 8192;
    off = (d >= 0) ? d / 64 : -((-d + 63) / 64);
    p   = note * 64 + off;
    if (p < 0) p = 0;
    if (p > 8128) p = 8128;
    return p;
  endfunction

  function automatic int model_adder(int note, int bend);
    int p, s, f, oct, r, m;
    p   = model_pitch(note, bend);
    s   = p / 64;
    f   = p % 64;
    oct = s / 12;
    r   = s % 12;
    m   = tbl[r] + ((tbl[r+1] - tbl[r]) * f) / 64;
    return m / (1 << (10 - oct));
  endfunction

  function automatic int model_lat(int note, int bend);
    return model_pitch(note, bend) / 64 / 12 + 3;
  endfunction

  function automatic logic [127:0] model_bus();
    logic [127:0] b;
    for (int v = 0; v < 4; v++) b[v*32 +: 32] = 32'(exp_adder[v]);
    return b;
  endfunction

  // Issues one request and watches 20 cycles; hold keeps a conflicting request asserted while busy.
  task automatic drive_req(input int note, input int bend, input int voice, input bit hold,
                           output int lat, output int dv, output int ndone, output int rlow,
                           output logic [127:0] bus_at_done);
    int w;
    w = 0;
    @(negedge CLK);
    while (!REQ_READY && w < 50) begin
      @(negedge CLK);
      w++;
    end
    if (!REQ_READY) begin
      n_checks++;
      $display("FAIL ready_timeout: REQ_READY=%0b after %0d cycles, required 1", REQ_READY, w);
    end
    NOTE = 7'(note); BEND = 14'(bend); VOICE = 4'(voice); REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    if (hold) begin
      NOTE = 7'd10; BEND = 14'd8192; VOICE = 4'd1;
    end else begin
      REQ_VALID = 1'b0;
    end
    rlow = REQ_READY ? 0 : 1;
    lat = -1; dv = -1; ndone = 0; bus_at_done = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      if (!REQ_READY) rlow++;
      if (DONE) begin
        ndone++;
        if (lat < 0) begin
          lat = k; dv = int'(DONE_VOICE); bus_at_done = ADDER_BUS;
        end
        REQ_VALID = 1'b0;
      end
      if (k == 20) REQ_VALID = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; REQ_VALID = 1'b0; NOTE = '0; BEND = 14'd8192; VOICE = '0;
    #1 RST = 1'b1;
    #2;
    n_checks++;
    if (ADDER_BUS !== '0) $display("FAIL reset_bus: got %h, required 0", ADDER_BUS); else n_pass++;
    n_checks++;
    if (REQ_READY !== 1'b1) $display("FAIL reset_ready: got %b, required 1", REQ_READY); else n_pass++;
    n_checks++;
    if (DONE !== 1'b0 || DONE_VOICE !== 4'd0)
      $display("FAIL reset_done: DONE=%b DONE_VOICE=%0d, required 0/0", DONE, DONE_VOICE);
    else n_pass++;
    for (int v = 0; v < 4; v++) exp_adder[v] = 0;
    #3 RST = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic test_max_note();
    int lat, dv, nd, rl;
    logic [127:0] bd;
    drive_req(127, 8192, 0, 1'b0, lat, dv, nd, rl, bd);
    exp_adder[0] = 538754;
    n_checks++;
    if (lat !== 13) $display("FAIL max_latency: got %0d, required 13", lat); else n_pass++;
    n_checks++;
    if (nd !== 1 || dv !== 0) $display("FAIL max_done: pulses=%0d voice=%0d, required 1/0", nd, dv); else n_pass++;
    n_checks++;
    if (bd !== model_bus()) $display("FAIL max_bus: got %h, required %h", bd, model_bus()); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    int lat, dv, nd, rl;
    logic [127:0] bd;
    drive_req(69, 8192, 2, 1'b1, lat, dv, nd, rl, bd);
    exp_adder[2] = 18897;
    n_checks++;
    if (lat !== 8) $display("FAIL busy_latency: got %0d, required 8", lat); else n_pass++;
    n_checks++;
    if (rl !== 8) $display("FAIL busy_ready_low: got %0d cycles, required 8", rl); else n_pass++;
    n_checks++;
    if (nd !== 1 || dv !== 2) $display("FAIL busy_done: pulses=%0d voice=%0d, required 1/2", nd, dv); else n_pass++;
    n_checks++;
    if (ADDER_BUS !== model_bus()) $display("FAIL busy_bus: got %h, required %h", ADDER_BUS, model_bus()); else n_pass++;
    n_checks++;
    if (REQ_READY !== 1'b1 || DONE !== 1'b0)
      $display("FAIL busy_idle_after: READY=%b DONE=%b, required 1/0", REQ_READY, DONE);
    else n_pass++;
  endtask

  task automatic test_bend();
    int lat, dv, nd, rl;
    logic [127:0] bd;
    drive_req(60, 16383, 1, 1'b0, lat, dv, nd, rl, bd);
    exp_adder[1] = 12601;
    n_checks++;
    if (lat !== 8 || dv !== 1) $display("FAIL bend_timing: lat=%0d voice=%0d, required 8/1", lat, dv); else n_pass++;
    n_checks++;
    if (bd[63:32] !== 32'd12601) $display("FAIL bend_value: got %0d, required 12601", bd[63:32]); else n_pass++;
  endtask

  task automatic test_clamps();
    int lat, dv, nd, rl;
    logic [127:0] bd;
    drive_req(0, 0, 3, 1'b0, lat, dv, nd, rl, bd);
    exp_adder[3] = 351;
    n_checks++;
    if (lat !== 3 || bd !== model_bus())
      $display("FAIL clamp_low: lat=%0d bus=%h, required 3/%h", lat, bd, model_bus());
    else n_pass++;
    drive_req(127, 16383, 3, 1'b0, lat, dv, nd, rl, bd);
    exp_adder[3] = 538754;
    n_checks++;
    if (lat !== 13 || bd[127:96] !== 32'd538754)
      $display("FAIL clamp_high: lat=%0d v3=%0d, required 13/538754", lat, bd[127:96]);
    else n_pass++;
    drive_req(0, 0, 7, 1'b0, lat, dv, nd, rl, bd);
    n_checks++;
    if (nd !== 0) $display("FAIL bad_voice_done: pulses=%0d, required 0", nd); else n_pass++;
    n_checks++;
    if (ADDER_BUS !== model_bus()) $display("FAIL bad_voice_bus: got %h, required %h", ADDER_BUS, model_bus()); else n_pass++;
  endtask

  task automatic test_random();
    int lat, dv, nd, rl, note, bend, voice, elat;
    logic [127:0] bd;
    for (int i = 0; i < 16; i++) begin
      note  = int'($urandom_range(0, 127));
      bend  = int'($urandom_range(0, 16383));
      voice = int'($urandom_range(0, 7));
      drive_req(note, bend, voice, 1'b0, lat, dv, nd, rl, bd);
      if (voice < 4) begin
        exp_adder[voice] = model_adder(note, bend);
        elat = model_lat(note, bend);
        n_checks++;
        if (lat !== elat || dv !== voice || nd !== 1)
          $display("FAIL rand%0d_timing n=%0d b=%0d: lat=%0d voice=%0d pulses=%0d, required %0d/%0d/1",
                   i, note, bend, lat, dv, nd, elat, voice);
        else n_pass++;
        n_checks++;
        if (bd !== model_bus())
          $display("FAIL rand%0d_bus n=%0d b=%0d v=%0d: got %h, required %h", i, note, bend, voice, bd, model_bus());
        else n_pass++;
      end else begin
        n_checks++;
        if (nd !== 0 || ADDER_BUS !== model_bus())
          $display("FAIL rand%0d_badvoice v=%0d: pulses=%0d bus=%h, required 0/%h", i, voice, nd, ADDER_BUS, model_bus());
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int lat, seen;
    @(negedge CLK);
    NOTE = 7'd127; BEND = 14'd8192; VOICE = 4'd0; REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    for (int v = 0; v < 4; v++) exp_adder[v] = 0;
    n_checks++;
    if (REQ_READY !== 1'b1 || DONE !== 1'b0 || ADDER_BUS !== '0)
      $display("FAIL midrst_async: READY=%b DONE=%b bus=%h, required 1/0/0", REQ_READY, DONE, ADDER_BUS);
    else n_pass++;
    seen = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (DONE) seen++;
    end
    @(negedge CLK);
    RST = 1'b0;
    NOTE = 7'd69; BEND = 14'd8192; VOICE = 4'd2; REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    n_checks++;
    if (REQ_READY !== 1'b0) $display("FAIL midrst_accept: READY=%b after first edge, required 0", REQ_READY); else n_pass++;
    lat = -1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge CLK); #1;
      if (DONE && lat < 0) lat = k;
      if (k < 8 && DONE) seen++;
    end
    exp_adder[2] = 18897;
    n_checks++;
    if (seen !== 0) $display("FAIL midrst_stale_done: %0d pulses, required 0", seen); else n_pass++;
    n_checks++;
    if (lat !== 8 || ADDER_BUS !== model_bus())
      $display("FAIL midrst_after: lat=%0d bus=%h, required 8/%h", lat, ADDER_BUS, model_bus());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_max_note();
    test_busy_ignore();
    test_bend();
    test_clamps();
    test_random();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
